// File: rtl/mem_arbiter.sv
// Purpose: arbitrates a CPU and a DMA requester onto one single-ported memory, with a bounded DMA lock.
// Latency: request sampled in IDLE, WAIT+1 strobe cycles, one-cycle ack WAIT+2 cycles after the request.
// Backpressure: level requests stall (cpu_stall) until the ack; inputs are only looked at in IDLE.
module mem_arbiter #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int WAIT     = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_C     = 4'(WAIT);
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);
  localparam logic [1:0] G_NONE     = 2'b00;
  localparam logic [1:0] G_CPU      = 2'b01;
  localparam logic [1:0] G_DMA      = 2'b10;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    grant_q;
  logic          last_dma_q;
  logic [7:0]    lock_cnt_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
  logic          any_req;
  logic          lock_hold;
  logic          pick_dma;

  // Arbitration: a lone requester wins; a tie goes round-robin unless DMA still holds an unexhausted lock.
  always_comb begin
    any_req   = cpu_req | dma_req;
    lock_hold = last_dma_q && (lock_cnt_q != 8'd0) && (lock_cnt_q < LOCK_MAX_C);
    pick_dma  = dma_req;
    if (cpu_req && dma_req) begin
      pick_dma = lock_hold || !last_dma_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes/acks; ACC ends once the wait counter has reached zero.
  always_comb begin
    state_d = state_q;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = ACC;
      end
      ACC: begin
        mem_re = ~we_q;
        mem_we = we_q;
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        cpu_ack = (grant_q == G_CPU);
        dma_ack = (grant_q == G_DMA);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access datapath: latch the winner in IDLE, count down and capture read data in ACC, settle lock in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= G_NONE;
      last_dma_q  <= 1'b1;
      lock_cnt_q  <= 8'd0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q    <= pick_dma ? G_DMA : G_CPU;
            last_dma_q <= pick_dma;
            we_q       <= pick_dma ? dma_we : cpu_we;
            addr_q     <= pick_dma ? dma_addr : cpu_addr;
            wdata_q    <= pick_dma ? dma_wdata : cpu_wdata;
            cnt_q      <= WAIT_C;
            if (!pick_dma) lock_cnt_q <= 8'd0;
          end
        end
        ACC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!we_q) begin
            if (grant_q == G_DMA) dma_rdata_q <= mem_rdata;
            else                  cpu_rdata_q <= mem_rdata;
          end
        end
        RESP: begin
          grant_q <= G_NONE;
          // dma_lock is only meaningful in the DMA's own response cycle; the count saturates at LOCK_MAX.
          if (grant_q == G_DMA) begin
            if (!dma_lock) lock_cnt_q <= 8'd0;
            else if (lock_cnt_q != LOCK_MAX_C) lock_cnt_q <= lock_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter DW, 16, data width.
REQ-002 SHALL provide parameter AW, 16, address width.
REQ-003 SHALL provide parameter WAIT, 1, memory wait cycles per access (0..15).
REQ-004 SHALL provide parameter LOCK_MAX, 8, maximum consecutive locked DMA grants (1..255).
REQ-005 SHALL have ports, one clock; reset is asynchronous and active-low:
 clk  in  1  clock, all state on rising edge
 reset  in  1  asynchronous active-low reset
 cpu_req  in  1  CPU access request (level)
 cpu_we  in  1  1=write, 0=read
 cpu_addr  in  AW  CPU address
 cpu_wdata  in  DW  CPU write data
 cpu_rdata  out  DW  CPU read data, valid while cpu_ack=1
 cpu_ack  out  1  one-cycle completion pulse
 cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
 dma_req  in  1  DMA access request (level)
 dma_we  in  1  1=write, 0=read
 dma_addr  in  AW  DMA address
 dma_wdata  in  DW  DMA write data
 dma_lock  in  1  request to keep priority for next access
 dma_rdata  out  DW  DMA read data, valid while dma_ack=1
 dma_ack  out  1  one-cycle completion pulse
 mem_re  out  1  memory read strobe
 mem_we  out  1  memory write strobe
 mem_addr  out  AW  memory address
 mem_wdata  out  DW  memory write data
 mem_rdata  in  DW  memory read data
 grant  out  2  00 none, 01 CPU, 10 DMA; 11 never driven
 busy  out  1  state != IDLE

Function
REQ-006 SHALL implement FSM states IDLE, ACC, RESP.
REQ-007 IDLE: if any req sampled high -> arbitrate, latch winner's we/addr/wdata, set grant, load wait counter with WAIT, go ACC; else stay IDLE, grant=00.
REQ-008 ACC: mem_re=~we_l, mem_we=we_l, mem_addr/mem_wdata from latched values, held stable; counter decrements each cycle; at counter==0 capture mem_rdata (reads only), go RESP; ACC lasts exactly WAIT+1 cycles.
REQ-009 RESP: strobes low, granted requester's ack=1 for exactly one cycle, its rdata register driven; grant held; next state IDLE.
REQ-010 Latency: req high in IDLE cycle 0 -> ack in cycle WAIT+2; back-to-back accesses from one requester occur every WAIT+3 cycles.
REQ-011 Requests SHALL be sampled only in IDLE; req/addr/data changes during ACC/RESP SHALL be ignored; req still high at next IDLE starts a new access.
REQ-012 Arbitration: single requester wins; on tie, round-robin against last-granted requester, except REQ-013.
REQ-013 Lock: if DMA was last granted, dma_lock=1 in its RESP cycle, and lock count < LOCK_MAX, DMA wins the next tie; lock count increments per locked DMA grant, clears on any CPU grant or unlocked DMA grant.
REQ-014 When lock count == LOCK_MAX, CPU SHALL win the next tie regardless of dma_lock.
REQ-015 cpu_rdata/dma_rdata SHALL hold last captured value outside ack; write accesses SHALL not update rdata.
REQ-016 grant 11, mem_re&mem_we both high, or any ack outside RESP SHALL never occur.
REQ-017 WAIT=0 SHALL give a single ACC cycle, ack in cycle 2.

Reset
REQ-018 reset low SHALL asynchronously force IDLE; grant=00, busy, acks, mem_re, mem_we=0; mem_addr, mem_wdata, rdata registers, counter, lock count=0; last-granted=DMA (CPU wins first tie).
REQ-019 reset asserted mid-ACC SHALL abort the access with no ack; first access after release SHALL restart arbitration from IDLE.

Verification
REQ-020 CPU read alone, WAIT=1: cpu_req=1, addr=0x0010, mem_rdata=0xBEEF -> mem_re cycles 1-2, cpu_ack and cpu_rdata=0xBEEF cycle 3, grant=01 cycles 1-3.
REQ-021 Tie after reset: cpu_req=dma_req=1 in cycle 0 -> CPU first (ack cycle 3), DMA second (ack cycle 7), alternating thereafter.
REQ-022 DMA write lock: dma_lock=1, dma_we=1, cpu_req=1 constant, LOCK_MAX=8 -> after first CPU grant, 8 consecutive DMA writes, then one CPU access; mem_we never with mem_re.
REQ-023 Reset mid-ACC: reset low in cycle 1 of DMA read -> no dma_ack, all outputs zero immediately; after release, cpu_req gets grant=01.
REQ-024 Input change during ACC: cpu_addr 0x0020->0x0030 in cycle 1 -> mem_addr stays 0x0020 through ACC.
REQ-025 WAIT=0 CPU write 0x1234 to 0x0004 -> mem_we cycle 1 only, cpu_ack cycle 2, cpu_rdata unchanged.
